cordic_mc: RTL and testbench

CORDIC_MC -- requirements
Module: cordic_mc

---
 rtl/cordic_pkg.sv | 15 +
 rtl/cordic_micro_rot.sv | 34 +++
 rtl/cordic_mc.sv | 118 +++++++++++
 tb/tb_cordic_mc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encodings, FSM states and constant generators for the CORDIC core
package cordic_pkg;
    localparam logic [1:0] MODE_VEC = 2'd1;
    localparam logic [1:0] MODE_ROT = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_POST, S_OUT} state_t;

    function automatic int atan_entry(input int i, input int w);
        return $rtoi($atan(1.0 / (2.0 ** i)) / 3.14159265358979 * (2.0 ** (w - 1)) + 0.5);
    endfunction

    function automatic int kinv(input int w);
        return $rtoi(0.607253 * (2.0 ** w) + 0.5);
    endfunction
endpackage

// File: rtl/cordic_micro_rot.sv
// cordic_micro_rot: one shift-add CORDIC step, steered by sign(y) when vectoring or sign(z) when rotating
module cordic_micro_rot
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DW    = WIDTH + 2,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic signed [DW-1:0]    x,
    input  logic signed [DW-1:0]    y,
    input  logic signed [WIDTH-1:0] z,
    input  logic [SW-1:0]           sh,
    input  logic [1:0]              mode,
    output logic signed [DW-1:0]    x_n,
    output logic signed [DW-1:0]    y_n,
    output logic signed [WIDTH-1:0] z_n
);
    logic signed [WIDTH-1:0] atan_tab [WIDTH];
    logic signed [WIDTH-1:0] atan;
    logic signed [DW-1:0]    xs, ys;
    logic                    ccw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tab
        assign atan_tab[i] = WIDTH'(atan_entry(i, WIDTH));
    end

    assign atan = atan_tab[sh];
    assign xs   = x >>> sh;
    assign ys   = y >>> sh;
    assign ccw  = (mode == MODE_ROT) ? !z[WIDTH-1] : y[DW-1];
    assign x_n  = ccw ? x - ys : x + ys;
    assign y_n  = ccw ? y + xs : y - xs;
    assign z_n  = ccw ? z - atan : z + atan;
endmodule

// File: rtl/cordic_mc.sv
// cordic_mc: iterative CORDIC (vectoring/rotation) reusing one micro-rotation, with tag and error flag
module cordic_mc
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int TAG_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   r_out,
    output logic signed [WIDTH:0]   a_out,
    output logic [TAG_W-1:0]        tag_out,
    output logic                    err_out
);
    localparam int DW = WIDTH + 2;
    localparam int SW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] QTR    = WIDTH'(1 << (WIDTH - 2));
    localparam logic signed [WIDTH-1:0] NEG180 = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic signed [DW-1:0]    KINV   = DW'(kinv(WIDTH));

    state_t                  state, state_d;
    logic [SW-1:0]           cnt;
    logic [1:0]              mode;
    logic signed [DW-1:0]    x, y, x_n, y_n, sx, sy;
    logic signed [WIDTH-1:0] z, z_n, z_f;
    logic signed [2*DW-1:0]  px, py;
    logic [TAG_W-1:0]        tag;
    logic                    zero, neg, accept, vec, legal;

    function automatic logic signed [WIDTH:0] sat(input logic signed [DW-1:0] v);
        return (v[DW-1] != v[DW-2]) ? {v[DW-1], {WIDTH{~v[DW-1]}}} : v[WIDTH:0];
    endfunction

    assign in_ready  = state == S_IDLE || (state == S_OUT && out_ready);
    assign out_valid = state == S_OUT;
    assign accept    = in_valid && in_ready;
    assign vec       = mode == MODE_VEC;
    assign legal     = vec || mode == MODE_ROT;
    // +180 and -180 share one encoding, so the vectoring start angle is NEG180 for either sign of y
    assign neg = vec ? x[DW-1] : (z > QTR || z < -QTR);
    assign z_f = vec ? (x[DW-1] ? NEG180 : '0) : (neg ? z ^ NEG180 : z);
    assign px  = (2*DW)'(x) * (2*DW)'(KINV);
    assign py  = (2*DW)'(y) * (2*DW)'(KINV);
    assign sx  = DW'(px >>> WIDTH);
    assign sy  = DW'(py >>> WIDTH);

    cordic_micro_rot #(.WIDTH(WIDTH)) u_rot (
        .x    (x),
        .y    (y),
        .z    (z),
        .sh   (cnt),
        .mode (mode),
        .x_n  (x_n),
        .y_n  (y_n),
        .z_n  (z_n)
    );

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = accept ? S_PRE : S_IDLE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  state_d = (cnt == SW'(ITER - 1)) ? S_POST : S_ITER;
            S_POST:  state_d = S_OUT;
            S_OUT:   state_d = !out_ready ? S_OUT : accept ? S_PRE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            r_out   <= '0;
            a_out   <= '0;
            tag_out <= '0;
            err_out <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                mode <= mode_in;
                x    <= DW'(x_in);
                y    <= DW'(y_in);
                z    <= z_in;
                tag  <= tag_in;
            end
            if (state == S_PRE) begin
                x    <= neg ? -x : x;
                y    <= neg ? -y : y;
                z    <= z_f;
                zero <= vec && x == '0 && y == '0;
                cnt  <= '0;
            end
            if (state == S_ITER) begin
                x   <= x_n;
                y   <= y_n;
                z   <= z_n;
                cnt <= cnt + 1'b1;
            end
            if (state == S_POST) begin
                r_out   <= (legal && !zero) ? sat(sx) : '0;
                a_out   <= (!legal || zero) ? '0 : vec ? (WIDTH + 1)'(z) : sat(sy);
                tag_out <= tag;
                err_out <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_cordic_mc.sv
// tb_cordic_mc: directed table, random ops against a real-arithmetic model, backpressure and reset sequences
module tb_cordic_mc;
    import cordic_pkg::*;
    localparam int W = 16;

    logic                clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic                in_ready, out_valid, err_out;
    logic [1:0]          mode_in = 2'd0, tag_in = 2'd0, tag_out;
    logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic signed [W:0]   r_out, a_out;
    int                  checks = 0, failures = 0;

    typedef struct {
        logic [1:0] m;
        int         x, y, z;
        logic [1:0] t;
        int         er, ea;
        logic       ee;
        int         tol;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    cordic_mc #(.WIDTH(W), .ITER(14), .TAG_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode_in   (mode_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .a_out     (a_out),
        .tag_out   (tag_out),
        .err_out   (err_out)
    );

    task automatic chk(input string nm, input int act, input int exp, input int tol, input bit wrap);
        int d = act - exp;
        if (wrap) d = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
        checks++;
        if (d > tol || d < -tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic void model(input logic [1:0] m, input int x, input int y, input int z,
                                  output int er, output int ea, output logic ee);
        real pi = 3.14159265358979;
        real xr = x;
        real yr = y;
        real th = z * pi / 32768.0;
        er = 0;
        ea = 0;
        ee = !(m == MODE_VEC || m == MODE_ROT);
        if (m == MODE_VEC) begin
            er = int'($sqrt(xr * xr + yr * yr));
            ea = int'($atan2(yr, xr) / pi * 32768.0);
        end else if (m == MODE_ROT) begin
            er = int'(xr * $cos(th) - yr * $sin(th));
            ea = int'(xr * $sin(th) + yr * $cos(th));
        end
    endfunction

    task automatic start_op(input logic [1:0] m, input int x, input int y, input int z, input logic [1:0] t);
        int n = 0;
        mode_in  = m;
        x_in     = W'(x);
        y_in     = W'(y);
        z_in     = W'(z);
        tag_in   = t;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", int'(in_ready), 1, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] m, input int x, input int y, input int z, input logic [1:0] t,
                          input int er, input int ea, input logic ee, input int tol, input string nm);
        int lat;
        start_op(m, x, y, z, t);
        wait_out(lat);
        chk({nm, "_latency"}, lat, 16, 0, 0);
        chk({nm, "_r"}, int'(r_out), er, tol, 0);
        chk({nm, "_a"}, int'(a_out), ea, tol, m == MODE_VEC);
        chk({nm, "_tag"}, int'(tag_out), int'(t), 0, 0);
        chk({nm, "_err"}, int'(err_out), int'(ee), 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, seen, r0, a0, t0;
        tbl[0]  = '{MODE_VEC, 32767, 0, 0, 2'd1, 32767, 0, 1'b0, 4};
        tbl[1]  = '{MODE_VEC, 32767, 32767, 0, 2'd2, 46340, 8192, 1'b0, 4};
        tbl[2]  = '{MODE_VEC, -32768, 0, 0, 2'd0, 32768, -32768, 1'b0, 4};
        tbl[3]  = '{MODE_ROT, 32767, 0, 16384, 2'd3, 0, 32767, 1'b0, 4};
        tbl[4]  = '{MODE_ROT, 32767, 0, -24576, 2'd1, -23170, -23170, 1'b0, 4};
        tbl[5]  = '{2'd0, 1000, 2000, 300, 2'd3, 0, 0, 1'b1, 0};
        tbl[6]  = '{2'd3, -5000, 7000, -900, 2'd2, 0, 0, 1'b1, 0};
        tbl[7]  = '{MODE_VEC, 0, 0, 1234, 2'd1, 0, 0, 1'b0, 0};
        tbl[8]  = '{MODE_ROT, 0, -32768, -32768, 2'd0, 0, 32768, 1'b0, 4};
        tbl[9]  = '{MODE_VEC, -20000, -20000, 0, 2'd2, 28284, -24576, 1'b0, 4};
        tbl[10] = '{MODE_ROT, 10000, 0, 16385, 2'd3, -1, 10000, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0, 0, 0);
        chk("reset_in_ready", int'(in_ready), 1, 0, 0);
        chk("reset_r", int'(r_out), 0, 0, 0);
        chk("reset_a", int'(a_out), 0, 0, 0);
        chk("reset_tag", int'(tag_out), 0, 0, 0);
        chk("reset_err", int'(err_out), 0, 0, 0);
        rst = 1'b0;

        for (int k = 0; k < 11; k++)
            run_op(tbl[k].m, tbl[k].x, tbl[k].y, tbl[k].z, tbl[k].t,
                   tbl[k].er, tbl[k].ea, tbl[k].ee, tbl[k].tol, $sformatf("tbl%0d", k));

        for (int k = 0; k < 36; k++) begin
            logic [1:0] m;
            int x, y, z, er, ea, sel;
            logic ee;
            sel = int'($urandom_range(0, 9));
            m = (sel < 4) ? MODE_VEC : (sel < 8) ? MODE_ROT : (sel == 8) ? 2'd0 : 2'd3;
            z = int'($urandom_range(0, 65535)) - 32768;
            if (m == MODE_VEC) begin
                do begin
                    x = int'($urandom_range(0, 40000)) - 20000;
                    y = int'($urandom_range(0, 40000)) - 20000;
                end while (x * x + y * y < 100000000);
            end else begin
                x = int'($urandom_range(0, 24000)) - 12000;
                y = int'($urandom_range(0, 24000)) - 12000;
            end
            model(m, x, y, z, er, ea, ee);
            run_op(m, x, y, z, 2'($urandom_range(0, 3)), er, ea, ee, ee ? 0 : 4, $sformatf("rnd%0d", k));
        end

        out_ready = 1'b0;
        start_op(MODE_VEC, 32767, 32767, 0, 2'd1);
        wait_out(lat);
        chk("bp_latency", lat, 16, 0, 0);
        chk("bp_r", int'(r_out), 46340, 4, 0);
        r0 = int'(r_out);
        a0 = int'(a_out);
        t0 = int'(tag_out);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", int'(out_valid), 1, 0, 0);
            chk("bp_in_ready_low", int'(in_ready), 0, 0, 0);
            chk("bp_r_stable", int'(r_out), r0, 0, 0);
            chk("bp_a_stable", int'(a_out), a0, 0, 0);
            chk("bp_tag_stable", int'(tag_out), t0, 0, 0);
        end
        mode_in   = MODE_ROT;
        x_in      = 16'sd32767;
        y_in      = '0;
        z_in      = -16'sd24576;
        tag_in    = 2'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", int'(in_ready), 1, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_out_valid_drop", int'(out_valid), 0, 0, 0);
        wait_out(lat);
        chk("b2b_latency", lat, 16, 0, 0);
        chk("b2b_r", int'(r_out), -23170, 4, 0);
        chk("b2b_a", int'(a_out), -23170, 4, 0);
        chk("b2b_tag", int'(tag_out), 2, 0, 0);
        @(posedge clk); #1;

        start_op(MODE_VEC, 12000, 5000, 0, 2'd3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", int'(out_valid), 0, 0, 0);
        chk("midrst_in_ready", int'(in_ready), 1, 0, 0);
        chk("midrst_r", int'(r_out), 0, 0, 0);
        chk("midrst_a", int'(a_out), 0, 0, 0);
        chk("midrst_tag", int'(tag_out), 0, 0, 0);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        chk("midrst_no_stale", seen, 0, 0, 0);

        mode_in  = MODE_ROT;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        chk("rst_over_accept", seen, 0, 0, 0);

        run_op(MODE_ROT, 20000, 0, 8192, 2'd1, 14142, 14142, 1'b0, 4, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
